univ_shift_reg: RTL and testbench

//   Parametrised universal shift/rotate engine; successor to the fixed 4-bit left/right shifter.

---
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 tb/tb_univ_shift_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift/rotate register: one command per start, one bit position
// per clock, with a start/busy/done handshake and serial in/out for chaining.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // 3'b110 and 3'b111 both decode as NOP through the case default
  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_NOP  = 3'b110
  } op_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] dout_d;
  logic             sout_d, busy_d, done_d;
  logic             op_is_shift;

  // LOAD and NOP take no steps, so only shift/rotate ops load the counter
  assign op_is_shift = (op != OP_LOAD) && (op[2:1] != 2'b11);

  // Next-state, counter and datapath step selection
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    din_d   = din_q;
    dout_d  = dout;
    sout_d  = sout;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          din_d   = din;
          busy_d  = 1'b1;
          count_d = op_is_shift ? amt : '0;
        end
      end
      RUN: begin
        if (count_q != '0) begin
          count_d = count_q - AMT_W'(1);
          case (op_q)
            OP_SLL: begin
              dout_d = {dout[WIDTH-2:0], sin};
              sout_d = dout[WIDTH-1];
            end
            OP_SRL: begin
              dout_d = {sin, dout[WIDTH-1:1]};
              sout_d = dout[0];
            end
            OP_SRA: begin
              dout_d = {dout[WIDTH-1], dout[WIDTH-1:1]};
              sout_d = dout[0];
            end
            OP_ROL: begin
              dout_d = {dout[WIDTH-2:0], dout[WIDTH-1]};
              sout_d = dout[WIDTH-1];
            end
            OP_ROR: begin
              dout_d = {dout[0], dout[WIDTH-1:1]};
              sout_d = dout[0];
            end
            default: ;
          endcase
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (op_q == OP_LOAD) dout_d = din_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      count_q <= '0;
      din_q   <= '0;
      dout    <= '0;
      sout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      din_q   <= din_d;
      dout    <= dout_d;
      sout    <= sout_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout, busy, done;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt), .din(din),
    .sin(sin), .dout(dout), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait (bounded) for done, check latency, result and pulse width
  task automatic run_cmd(input string tag, input logic [2:0] o, input logic [AMT_W-1:0] a,
                         input logic [7:0] d, input logic s, input int exp_lat,
                         input logic [7:0] exp_dout, input logic exp_sout);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; amt = a; din = d; sin = s;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_acc"}, busy, 1);
    check({tag, "_done_acc"}, done, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_dout"}, dout, exp_dout);
    check({tag, "_sout"}, sout, exp_sout);
    check({tag, "_busy_done"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    int n;
    bit seen;
    int pulses;
    rst = 1'b0; start = 1'b0; op = '0; amt = '0; din = '0; sin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;

    // T2 load
    run_cmd("load_a5", 3'b000, 4'd5, 8'hA5, 1'b0, 1, 8'hA5, 1'b0);
    // T3 SLL with sin=1, then SRA
    run_cmd("sll3", 3'b001, 4'd3, 8'h00, 1'b1, 4, 8'h2F, 1'b1);
    run_cmd("load_90", 3'b000, 4'd0, 8'h90, 1'b0, 1, 8'h90, 1'b1);
    run_cmd("sra2", 3'b011, 4'd2, 8'h00, 1'b1, 3, 8'hE4, 1'b0);
    // T4 rotates
    run_cmd("load_81", 3'b000, 4'd0, 8'h81, 1'b0, 1, 8'h81, 1'b0);
    run_cmd("ror1", 3'b101, 4'd1, 8'h00, 1'b0, 2, 8'hC0, 1'b1);
    run_cmd("load_3c", 3'b000, 4'd0, 8'h3C, 1'b0, 1, 8'h3C, 1'b1);
    run_cmd("rol8", 3'b100, 4'd8, 8'h00, 1'b0, 9, 8'h3C, 1'b0);
    // T5 amt=0 and NOP
    run_cmd("load_5a", 3'b000, 4'd0, 8'h5A, 1'b0, 1, 8'h5A, 1'b0);
    run_cmd("srl0", 3'b010, 4'd0, 8'hFF, 1'b1, 1, 8'h5A, 1'b0);
    run_cmd("nop110", 3'b110, 4'd3, 8'hFF, 1'b1, 1, 8'h5A, 1'b0);
    run_cmd("nop111", 3'b111, 4'd2, 8'h00, 1'b1, 1, 8'h5A, 1'b0);
    run_cmd("srl3", 3'b010, 4'd3, 8'h00, 1'b0, 4, 8'h0B, 1'b0);
    // amt beyond width: only sin history remains
    run_cmd("load_00", 3'b000, 4'd0, 8'h00, 1'b0, 1, 8'h00, 1'b0);
    run_cmd("sll9", 3'b001, 4'd9, 8'h00, 1'b1, 10, 8'hFF, 1'b1);

    // T6 start during RUN ignored, start in done cycle accepted
    run_cmd("load_0f", 3'b000, 4'd0, 8'h0F, 1'b0, 1, 8'h0F, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 3'b001; amt = 4'd3; din = 8'h00; sin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b000; amt = 4'd1; din = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check("busy_ign_lat", n, 3);
    check("busy_ign_dout", dout, 8'h78);
    check("busy_ign_sout", sout, 0);
    start = 1'b1; op = 3'b101; amt = 4'd4; din = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1;
    end
    check("b2b_lat", n, 5);
    check("b2b_dout", dout, 8'h87);
    check("b2b_sout", sout, 1);

    // T1 reset mid-RUN aborts without a done pulse
    run_cmd("load_ff", 3'b000, 4'd0, 8'hFF, 1'b0, 1, 8'hFF, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 3'b010; amt = 4'd5; sin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_dout", dout, 0);
    check("abort_sout", sout, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("abort_no_done", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
